// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Alarm sequencing controller for the alarm clock. It runs beside
// clock_counter and does four jobs:
//   - stores the alarm time entered as BCD digits
//   - generates a one-cycle time-load strobe from the time-set button
//   - detects when the current time matches the alarm time
//   - runs the IDLE / ARMED / RINGING / SNOOZED state machine that drives
//     the alarm sound output
// One clk cycle is one clock second.
//
// Parameters:
//   RING_TIMEOUT  cycles the alarm rings before stopping by itself (1..255)
//   SNOOZE_SEC    cycles spent snoozed before ringing again          (1..511)
//   MAX_SNOOZE    snoozes allowed per alarm event                    (0..7)
//
// Ports:
//   clk                  system clock, one tick per second
//   reset                asynchronous, active-low reset
//   H_in1/H_in0          BCD alarm hour digits (tens 2 bits, units 4 bits)
//   M_in1/M_in0          BCD alarm minute digits
//   LD_alarm             level; loads the alarm registers when valid
//   LD_time_btn          level; time-set button
//   AL_ON                alarm enable
//   STOP_al              stops ringing or snoozing
//   SNOOZE               snooze request while ringing
//   cur_hour/minute/second  binary time from clock_counter
//   LD_time              one-cycle load strobe to clock_counter
//   Alarm                alarm sound enable (registered)
//   al_state             0=IDLE 1=ARMED 2=RINGING 3=SNOOZED
//   snooze_cnt           snoozes used in the current alarm event
//   bad_cfg              last alarm load was rejected
//   alarm_hour/minute    stored alarm time, binary
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SEC   = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_alarm,
  input  logic       LD_time_btn,
  input  logic       AL_ON,
  input  logic       STOP_al,
  input  logic       SNOOZE,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       LD_time,
  output logic       Alarm,
  output logic [1:0] al_state,
  output logic [2:0] snooze_cnt,
  output logic       bad_cfg,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_minute
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } state_t;

  // Terminal timer values; a timer reaching these ends its phase on the
  // following edge, so each phase lasts exactly the parameter in cycles.
  localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
  localparam logic [2:0] SNOOZE_CAP  = 3'(MAX_SNOOZE);

  state_t     state_reg;
  logic       alarm_reg;
  logic [7:0] ring_timer_reg;
  logic [8:0] snooze_timer_reg;
  logic [2:0] snooze_cnt_reg;

  logic [5:0] alarm_hour_reg;
  logic [5:0] alarm_minute_reg;
  logic       bad_cfg_reg;

  logic       btn_prev_reg;
  logic       ld_time_reg;

  // ---------------------------------------------------------------------------
  // Alarm-time decode. Arithmetic is deliberately 6 bits wide: out-of-range
  // digit combinations wrap, and the range check is applied to the wrapped
  // value.
  // ---------------------------------------------------------------------------
  logic [5:0] load_hour;
  logic [5:0] load_minute;
  logic       load_ok;

  always_comb begin
    load_hour   = 6'(H_in1) * 6'd10 + 6'(H_in0);
    load_minute = 6'(M_in1) * 6'd10 + 6'(M_in0);
    load_ok     = (load_hour <= 6'd23) && (load_minute <= 6'd59);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hour_reg   <= 6'd0;
      alarm_minute_reg <= 6'd0;
      bad_cfg_reg      <= 1'b0;
    end else if (LD_alarm) begin
      if (load_ok) begin
        alarm_hour_reg   <= load_hour;
        alarm_minute_reg <= load_minute;
        bad_cfg_reg      <= 1'b0;
      end else begin
        // Registers keep the previous valid alarm; the flag stays up until
        // a valid load arrives.
        bad_cfg_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time-load strobe: registered rising-edge detect, so a held button gives
  // a single pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev_reg <= 1'b0;
      ld_time_reg  <= 1'b0;
    end else begin
      btn_prev_reg <= LD_time_btn;
      ld_time_reg  <= LD_time_btn & ~btn_prev_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Match: only on second 0, so after STOP the alarm cannot re-trigger in the
  // same minute; it next fires on the following day.
  // ---------------------------------------------------------------------------
  logic time_match;

  always_comb begin
    time_match = (cur_hour == alarm_hour_reg) &&
                 (cur_minute == alarm_minute_reg) &&
                 (cur_second == 6'd0);
  end

  // ---------------------------------------------------------------------------
  // Ring / snooze state machine. alarm_reg is written alongside state_reg on
  // every branch with (next state == RINGING) so Alarm and al_state change
  // on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      alarm_reg        <= 1'b0;
      ring_timer_reg   <= 8'd0;
      snooze_timer_reg <= 9'd0;
      snooze_cnt_reg   <= 3'd0;
    end else if (!AL_ON) begin
      // Disable overrides everything, including STOP/SNOOZE in the same cycle.
      state_reg        <= IDLE;
      alarm_reg        <= 1'b0;
      ring_timer_reg   <= 8'd0;
      snooze_timer_reg <= 9'd0;
      snooze_cnt_reg   <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= ARMED;
          alarm_reg <= 1'b0;
        end

        ARMED: begin
          if (time_match) begin
            state_reg      <= RINGING;
            alarm_reg      <= 1'b1;
            ring_timer_reg <= 8'd0;
          end else begin
            alarm_reg <= 1'b0;
          end
        end

        RINGING: begin
          if (STOP_al) begin
            state_reg      <= ARMED;
            alarm_reg      <= 1'b0;
            snooze_cnt_reg <= 3'd0;
          end else if (SNOOZE && (snooze_cnt_reg < SNOOZE_CAP)) begin
            state_reg        <= SNOOZED;
            alarm_reg        <= 1'b0;
            snooze_cnt_reg   <= snooze_cnt_reg + 3'd1;
            snooze_timer_reg <= 9'd0;
          end else if (ring_timer_reg == RING_LAST) begin
            // A snooze request beyond the cap falls through to here, so the
            // ring timeout is still honoured on the last cycle.
            state_reg      <= ARMED;
            alarm_reg      <= 1'b0;
            snooze_cnt_reg <= 3'd0;
          end else begin
            alarm_reg      <= 1'b1;
            ring_timer_reg <= ring_timer_reg + 8'd1;
          end
        end

        SNOOZED: begin
          if (STOP_al) begin
            state_reg      <= ARMED;
            alarm_reg      <= 1'b0;
            snooze_cnt_reg <= 3'd0;
          end else if (snooze_timer_reg == SNOOZE_LAST) begin
            state_reg      <= RINGING;
            alarm_reg      <= 1'b1;
            ring_timer_reg <= 8'd0;
          end else begin
            alarm_reg        <= 1'b0;
            snooze_timer_reg <= snooze_timer_reg + 9'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          alarm_reg <= 1'b0;
        end
      endcase
    end
  end

  assign LD_time      = ld_time_reg;
  assign Alarm        = alarm_reg;
  assign al_state     = state_reg;
  assign snooze_cnt   = snooze_cnt_reg;
  assign bad_cfg      = bad_cfg_reg;
  assign alarm_hour   = alarm_hour_reg;
  assign alarm_minute = alarm_minute_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
//
// Self-checking bench for alarm_controller (RING_TIMEOUT=5, SNOOZE_SEC=3,
// MAX_SNOOZE=2). A behavioural model tracks the alarm event in terms of
// elapsed ring/snooze seconds and snoozes used; every clock step compares
// all outputs against it. Directed scenarios are followed by a randomized
// phase.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

  localparam int RT = 5;
  localparam int SS = 3;
  localparam int MS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_alarm, LD_time_btn, AL_ON, STOP_al, SNOOZE;
  logic [5:0] cur_hour, cur_minute, cur_second;
  logic       LD_time, Alarm, bad_cfg;
  logic [1:0] al_state;
  logic [2:0] snooze_cnt;
  logic [5:0] alarm_hour, alarm_minute;

  always #5 clk = ~clk;

  alarm_controller #(
    .RING_TIMEOUT(RT),
    .SNOOZE_SEC  (SS),
    .MAX_SNOOZE  (MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .H_in1       (H_in1),
    .H_in0       (H_in0),
    .M_in1       (M_in1),
    .M_in0       (M_in0),
    .LD_alarm    (LD_alarm),
    .LD_time_btn (LD_time_btn),
    .AL_ON       (AL_ON),
    .STOP_al     (STOP_al),
    .SNOOZE      (SNOOZE),
    .cur_hour    (cur_hour),
    .cur_minute  (cur_minute),
    .cur_second  (cur_second),
    .LD_time     (LD_time),
    .Alarm       (Alarm),
    .al_state    (al_state),
    .snooze_cnt  (snooze_cnt),
    .bad_cfg     (bad_cfg),
    .alarm_hour  (alarm_hour),
    .alarm_minute(alarm_minute)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 armed, 2 ringing, 3 snoozed
  int m_mode, m_rung, m_slept, m_used;
  int m_ah, m_am;
  bit m_bad, m_btn_prev, m_ldt, m_alarm;

  task automatic model_reset();
    m_mode = 0; m_rung = 0; m_slept = 0; m_used = 0;
    m_ah = 0; m_am = 0; m_bad = 0; m_btn_prev = 0; m_ldt = 0; m_alarm = 0;
  endtask

  // Advance the model by one second using the inputs currently applied.
  task automatic model_clock();
    int h, m;
    bit match;
    match = (int'(cur_hour) == m_ah) && (int'(cur_minute) == m_am) && (cur_second == 0);
    if (LD_alarm) begin
      h = (int'(H_in1) * 10 + int'(H_in0)) % 64;
      m = (int'(M_in1) * 10 + int'(M_in0)) % 64;
      if (h <= 23 && m <= 59) begin m_ah = h; m_am = m; m_bad = 0; end
      else m_bad = 1;
    end
    m_ldt = LD_time_btn && !m_btn_prev;
    m_btn_prev = LD_time_btn;
    if (!AL_ON) begin
      m_mode = 0; m_used = 0; m_rung = 0; m_slept = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (match) begin m_mode = 2; m_rung = 0; end
    end else if (m_mode == 2) begin
      // m_rung counts seconds already rung in this burst
      if (STOP_al) begin m_mode = 1; m_used = 0; end
      else if (SNOOZE && m_used < MS) begin m_mode = 3; m_used++; m_slept = 0; end
      else if (m_rung + 1 >= RT) begin m_mode = 1; m_used = 0; end
      else m_rung++;
    end else begin
      if (STOP_al) begin m_mode = 1; m_used = 0; end
      else if (m_slept + 1 >= SS) begin m_mode = 2; m_rung = 0; end
      else m_slept++;
    end
    m_alarm = (m_mode == 2);
  endtask

  task automatic compare_all();
    check("Alarm", Alarm, m_alarm);
    check("al_state", al_state, m_mode);
    check("snooze_cnt", snooze_cnt, m_used);
    check("bad_cfg", bad_cfg, m_bad);
    check("alarm_hour", alarm_hour, m_ah);
    check("alarm_minute", alarm_minute, m_am);
    check("LD_time", LD_time, m_ldt);
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 6'(h); cur_minute = 6'(m); cur_second = 6'(s);
  endtask

  task automatic load_digits(input int d1, input int d0, input int d3, input int d2);
    H_in1 = 2'(d1); H_in0 = 4'(d0); M_in1 = 4'(d3); M_in0 = 4'(d2);
  endtask

  int cnt;

  initial begin
    reset = 1'b0;
    load_digits(0, 0, 0, 0);
    LD_alarm = 0; LD_time_btn = 0; AL_ON = 0; STOP_al = 0; SNOOZE = 0;
    set_time(12, 0, 1);
    model_reset();
    #3;
    compare_all();
    #5 reset = 1'b1;

    // ---- Load and arm ----
    load_digits(0, 7, 3, 0); LD_alarm = 1; AL_ON = 1;
    set_time(7, 29, 59);
    step();
    LD_alarm = 0;
    check("load_hour_7", alarm_hour, 7);
    check("load_min_30", alarm_minute, 30);
    check("armed", al_state, 1);
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
    cnt = Alarm ? 1 : 0;
    for (int i = 0; i < 20 && Alarm; i++) begin
      step();
      if (Alarm) cnt++;
    end
    check("ring_len", cnt, 5);
    check("after_timeout_state", al_state, 1);
    $display("txn load_arm: ring_len=%0d state=%0d", cnt, al_state);

    // ---- Rejected load then valid load ----
    load_digits(2, 5, 0, 0); LD_alarm = 1;
    step();
    check("bad_cfg_set", bad_cfg, 1);
    check("keep_hour", alarm_hour, 7);
    check("keep_min", alarm_minute, 30);
    load_digits(0, 6, 4, 5);
    step();
    LD_alarm = 0;
    check("new_hour", alarm_hour, 6);
    check("new_min", alarm_minute, 45);
    check("bad_cfg_clr", bad_cfg, 0);
    $display("txn reload: alarm=%0d:%0d bad=%0d", alarm_hour, alarm_minute, bad_cfg);

    // ---- Snooze cap ----
    set_time(6, 45, 0);
    step();
    set_time(6, 45, 1);
    for (int k = 0; k < 2; k++) begin
      SNOOZE = 1;
      step();
      SNOOZE = 0;
      cnt = Alarm ? 0 : 1;
      for (int i = 0; i < 20 && !Alarm; i++) begin
        step();
        if (!Alarm) cnt++;
      end
      check("snooze_gap", cnt, 3);
      $display("txn snooze %0d: silent=%0d cnt=%0d", k, cnt, snooze_cnt);
    end
    check("snooze_cnt_2", snooze_cnt, 2);
    SNOOZE = 1;
    step();
    SNOOZE = 0;
    check("third_snooze_ignored", al_state, 2);
    for (int i = 0; i < 20 && Alarm; i++) step();
    check("cap_timeout_state", al_state, 1);
    check("cap_cnt_clear", snooze_cnt, 0);

    // ---- STOP during SNOOZED ----
    set_time(6, 45, 0);
    step();
    set_time(6, 45, 1);
    SNOOZE = 1; step(); SNOOZE = 0;
    STOP_al = 1; step(); STOP_al = 0;
    check("stop_snoozed_state", al_state, 1);
    check("stop_snoozed_alarm", Alarm, 0);
    $display("txn stop_in_snooze: state=%0d", al_state);

    // ---- AL_ON=0 beats SNOOZE ----
    set_time(6, 45, 0);
    step();
    set_time(6, 45, 1);
    AL_ON = 0; SNOOZE = 1; step();
    check("alon_priority", al_state, 0);
    AL_ON = 1; SNOOZE = 0; step();
    $display("txn alon_off: state=%0d", al_state);

    // ---- Time-load strobe ----
    cnt = 0;
    LD_time_btn = 1;
    for (int i = 0; i < 10; i++) begin step(); if (LD_time) cnt++; end
    LD_time_btn = 0;
    step(); if (LD_time) cnt++;
    check("ld_pulse_1", cnt, 1);
    step();
    cnt = 0;
    LD_time_btn = 1;
    for (int i = 0; i < 3; i++) begin step(); if (LD_time) cnt++; end
    LD_time_btn = 0;
    step(); if (LD_time) cnt++;
    check("ld_pulse_2", cnt, 1);
    $display("txn ld_time: pulses=%0d", cnt);

    // ---- Reset mid-ring ----
    set_time(6, 45, 0);
    step();
    set_time(6, 45, 1);
    check("ringing_before_reset", Alarm, 1);
    #2 reset = 1'b0;
    #1;
    check("alarm_async_drop", Alarm, 0);
    model_reset();
    compare_all();
    #3 reset = 1'b1;
    $display("txn reset_mid_ring: alarm=%0d state=%0d", Alarm, al_state);

    // ---- Randomized phase ----
    for (int i = 0; i < 600; i++) begin
      LD_alarm = ($urandom % 8) == 0;
      H_in1 = 2'($urandom % 4); H_in0 = 4'($urandom % 16);
      M_in1 = 4'($urandom % 8); M_in0 = 4'($urandom % 16);
      if (($urandom % 4) == 0) LD_time_btn = ~LD_time_btn;
      AL_ON   = ($urandom % 25) != 0;
      STOP_al = ($urandom % 15) == 0;
      SNOOZE  = ($urandom % 6) == 0;
      if (($urandom % 3) == 0) set_time(m_ah, m_am, 0);
      else set_time($urandom % 24, $urandom % 60, $urandom % 60);
      step();
      if ((i % 50) == 0)
        $display("txn rand %0d: state=%0d alarm=%0d cnt=%0d", i, al_state, Alarm, snooze_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm sequencing controller for the alarm clock. It sits beside `clock_counter`, watches its binary hour/minute/second outputs and generates the one-cycle `LD_time` load strobe. It holds the alarm setting and runs the ring/snooze/stop state machine that drives the alarm output. One `clk` cycle equals one clock second, the same tick that advances `clock_counter`.

## Interface
Parameters:
- `RING_TIMEOUT`, default 60: number of cycles the alarm rings before it stops by itself (range 1..255).
- `SNOOZE_SEC`, default 300: number of cycles spent snoozed before ringing again (range 1..511).
- `MAX_SNOOZE`, default 3: number of snoozes allowed per alarm event (range 0..7).

Ports:
- `clk` in 1: system clock, one tick per second.
- `reset` in 1: asynchronous, active-low reset.
- `H_in1` in 2, `H_in0` in 4, `M_in1` in 4, `M_in0` in 4: BCD alarm-time digits.
- `LD_alarm` in 1: level input; loads the alarm registers.
- `LD_time_btn` in 1: level input from the time-set button.
- `AL_ON` in 1: alarm enable.
- `STOP_al` in 1: stops ringing.
- `SNOOZE` in 1: snooze request.
- `cur_hour`, `cur_minute`, `cur_second` in 6 each: binary time from `clock_counter`.
- `LD_time` out 1: one-cycle load strobe to `clock_counter`.
- `Alarm` out 1: alarm sound enable.
- `al_state` out 2: current state. IDLE=0, ARMED=1, RINGING=2, SNOOZED=3.
- `snooze_cnt` out 3: number of snoozes used in the current event.
- `bad_cfg` out 1: set when an alarm load was rejected.
- `alarm_hour`, `alarm_minute` out 6 each: stored alarm time, binary.

## Operation
- **Reset (`reset`=0):** applies immediately.
  - `al_state`=IDLE.
  - `Alarm`, `LD_time`, `bad_cfg`, `snooze_cnt`, `alarm_hour` and `alarm_minute` all 0.
  - Ring and snooze timers cleared.
- **Alarm load:**
  - In any cycle with `LD_alarm`=1, compute H=`H_in1`*10+`H_in0` and M=`M_in1`*10+`M_in0` at 6-bit width.
  - If H≤23 and M≤59: write the alarm registers and clear `bad_cfg`.
  - Otherwise: the registers keep their old value and `bad_cfg` is set to 1. `bad_cfg` stays set until the next valid load.
  - A load never changes `al_state`.
- **Time-load strobe:**
  - `LD_time` is a registered rising-edge detect of `LD_time_btn`, so it is high for exactly one cycle per press.
  - A held button produces no further strobes.
- **Match condition:** `cur_hour`==`alarm_hour`, `cur_minute`==`alarm_minute` and `cur_second`==0.
- **State machine:** inputs are sampled at the rising edge. The first applicable rule wins:
  - `AL_ON`=0: go to IDLE from any state. `snooze_cnt` and the timers clear.
  - IDLE with `AL_ON`=1: go to ARMED.
  - ARMED with a match: go to RINGING and clear the ring timer.
  - RINGING with `STOP_al`=1: go to ARMED and clear `snooze_cnt`.
  - RINGING with `SNOOZE`=1 and `snooze_cnt`<`MAX_SNOOZE`: go to SNOOZED. `snooze_cnt` increments and the snooze timer clears.
  - RINGING with `SNOOZE`=1 and `snooze_cnt`=`MAX_SNOOZE`: the request is ignored and ringing continues.
  - RINGING with ring timer=`RING_TIMEOUT`-1: go to ARMED and clear `snooze_cnt`.
  - SNOOZED with `STOP_al`=1: go to ARMED and clear `snooze_cnt`.
  - SNOOZED with snooze timer=`SNOOZE_SEC`-1: go to RINGING and clear the ring timer.
  - In all other cases, timers in the active state increment by 1.
- **`Alarm` output:** registered, equal to (next state == RINGING), so it changes on the same edge as `al_state`.
- **Re-trigger:** a match in ARMED re-triggers on the next day. Because the match requires `cur_second`==0, no re-trigger can occur within the same minute after STOP.

## Timing
- **Entering RINGING:** a match sampled at edge N gives `Alarm`=1 and `al_state`=2 after edge N.
- **Ring duration:** with no user input, `Alarm` is high for exactly `RING_TIMEOUT` cycles.
- **Snooze duration:** the snooze gap is exactly `SNOOZE_SEC` cycles with `Alarm`=0.
- **Input latency:** `STOP_al`, `SNOOZE` and `AL_ON` take effect one edge after they are sampled.
- **`LD_time` latency:** `LD_time` rises on the edge after the first cycle `LD_time_btn`=1 is sampled.
- **Reset mid-ring:** `Alarm` drops asynchronously.

## Test plan
Bench parameters: `RING_TIMEOUT`=5, `SNOOZE_SEC`=3, `MAX_SNOOZE`=2.
- **Load and arm:** load alarm 0,7,3,0, set `AL_ON`=1, drive the current time to 07:30:00.
  - `alarm_hour`=7, `alarm_minute`=30.
  - `Alarm` rises next edge and stays high for exactly 5 cycles, then `al_state`=1.
- **Rejected load:** load 2,5,0,0 (25:00).
  - `bad_cfg`=1 and the alarm registers keep 07:30.
  - A following load of 0,6,4,5 gives 06:45 and `bad_cfg`=0.
- **Snooze cap:** press `SNOOZE` during ringing three times.
  - Two snoozes of 3 silent cycles each, `snooze_cnt`=2.
  - The third press is ignored and ringing times out.
  - `snooze_cnt` then returns to 0.
- **STOP and AL_ON priority:**
  - `STOP_al` during SNOOZED gives ARMED with `Alarm`=0.
  - `AL_ON`=0 together with `SNOOZE`=1 during RINGING gives IDLE.
- **Time-load strobe:** hold `LD_time_btn` high for 10 cycles.
  - `LD_time` is high for exactly 1 cycle.
  - A second press after release gives one more pulse.
- **Reset mid-ring:** assert `reset`=0 during RINGING.
  - `Alarm`=0 immediately.
  - All outputs go to their reset values and `al_state`=0.
